// File: rtl/video_timing_gen_if.sv
// Raster timing bundle: pixel strobe, blanking/sync and counters
// from the timing generator to the pattern/framebuffer stage.
interface video_timing_gen_if;
  logic       ce_pix;
  logic       hblank;
  logic       hsync;
  logic       vblank;
  logic       vsync;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       line_rep;
  logic       frame_start;

  modport master (
    output ce_pix, hblank, hsync, vblank, vsync,
    output hcount, vcount, line_rep, frame_start
  );

  modport slave (
    input ce_pix, hblank, hsync, vblank, vsync,
    input hcount, vcount, line_rep, frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel clock-enable divider, h/v counters with NTSC/PAL
// frame length and scandoubling, registered blank/sync decode aligned to the counters.
module video_timing_gen #(
  parameter int CE_DIV       = 8,
  parameter int H_ACTIVE     = 256,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 32,
  parameter int H_TOTAL      = 340,
  parameter int V_ACTIVE     = 240,
  parameter int V_FP_NTSC    = 3,
  parameter int V_FP_PAL     = 27,
  parameter int V_SYNC       = 3,
  parameter int V_TOTAL_NTSC = 262,
  parameter int V_TOTAL_PAL  = 312
) (
  input  logic               sys_clk,
  input  logic               reset_n,
  input  logic               pal,
  input  logic               scandouble,
  video_timing_gen_if.master vid
);

  localparam int DIV_W = $clog2(CE_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST_N  = DIV_W'(CE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST_SD = DIV_W'(CE_DIV / 2 - 1);

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT_C    = 10'(H_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT_C    = 10'(V_ACTIVE);
  localparam logic [9:0] VN_LAST    = 10'(V_TOTAL_NTSC - 1);
  localparam logic [9:0] VP_LAST    = 10'(V_TOTAL_PAL - 1);
  localparam logic [9:0] VS_START_N = 10'(V_ACTIVE + V_FP_NTSC);
  localparam logic [9:0] VS_END_N   = 10'(V_ACTIVE + V_FP_NTSC + V_SYNC);
  localparam logic [9:0] VS_START_P = 10'(V_ACTIVE + V_FP_PAL);
  localparam logic [9:0] VS_END_P   = 10'(V_ACTIVE + V_FP_PAL + V_SYNC);

  logic [DIV_W-1:0] div_cnt_r, div_nxt_s, div_last_s;
  logic             ce_pix_r, ce_nxt_s;
  logic [9:0]       hcount_r, hcount_nxt_s;
  logic [9:0]       vcount_r, vcount_nxt_s, v_last_s;
  logic [9:0]       vs_start_s, vs_end_s;
  logic             line_rep_r, line_rep_nxt_s;
  logic             frame_wrap_s, sd_change_s;
  logic             pal_l_r, sd_l_r, pal_nxt_s, sd_nxt_s, init_r;
  logic             hblank_r, hsync_r, vblank_r, vsync_r, frame_start_r;
  logic             hblank_nxt_s, hsync_nxt_s, vblank_nxt_s, vsync_nxt_s;

  // Counter next-state: advance one pixel per ce_pix; lines repeat once when scandoubling
  always_comb begin
    hcount_nxt_s   = hcount_r;
    vcount_nxt_s   = vcount_r;
    line_rep_nxt_s = line_rep_r;
    frame_wrap_s   = 1'b0;
    v_last_s       = pal_l_r ? VP_LAST : VN_LAST;
    if (ce_pix_r) begin
      if (hcount_r == H_LAST) begin
        hcount_nxt_s = 10'd0;
        if (sd_l_r && !line_rep_r) begin
          line_rep_nxt_s = 1'b1;
        end else begin
          line_rep_nxt_s = 1'b0;
          if (vcount_r == v_last_s) begin
            vcount_nxt_s = 10'd0;
            frame_wrap_s = 1'b1;
          end else begin
            vcount_nxt_s = vcount_r + 10'd1;
          end
        end
      end else begin
        hcount_nxt_s = hcount_r + 10'd1;
      end
    end else begin
      hcount_nxt_s = hcount_r;
    end
  end

  // Mode capture, pixel divider and blank/sync decode from next-state counters
  always_comb begin
    pal_nxt_s = pal_l_r;
    sd_nxt_s  = sd_l_r;
    if (!init_r || frame_wrap_s) begin
      pal_nxt_s = pal;
      sd_nxt_s  = scandouble;
    end else begin
      pal_nxt_s = pal_l_r;
      sd_nxt_s  = sd_l_r;
    end
    sd_change_s = frame_wrap_s && (scandouble != sd_l_r);
    div_last_s  = sd_l_r ? DIV_LAST_SD : DIV_LAST_N;
    if (sd_change_s) begin
      div_nxt_s = '0;
      ce_nxt_s  = 1'b0;
    end else if (div_cnt_r == div_last_s) begin
      div_nxt_s = '0;
      ce_nxt_s  = 1'b1;
    end else begin
      div_nxt_s = div_cnt_r + DIV_W'(1);
      ce_nxt_s  = 1'b0;
    end
    vs_start_s   = pal_nxt_s ? VS_START_P : VS_START_N;
    vs_end_s     = pal_nxt_s ? VS_END_P : VS_END_N;
    hblank_nxt_s = (hcount_nxt_s >= H_ACT_C);
    hsync_nxt_s  = (hcount_nxt_s >= HS_START) && (hcount_nxt_s < HS_END);
    vblank_nxt_s = (vcount_nxt_s >= V_ACT_C);
    vsync_nxt_s  = (vcount_nxt_s >= vs_start_s) && (vcount_nxt_s < vs_end_s);
  end

  // State and output registers
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_r     <= '0;
      ce_pix_r      <= 1'b0;
      hcount_r      <= 10'd0;
      vcount_r      <= 10'd0;
      line_rep_r    <= 1'b0;
      pal_l_r       <= 1'b0;
      sd_l_r        <= 1'b0;
      init_r        <= 1'b0;
      hblank_r      <= 1'b0;
      hsync_r       <= 1'b0;
      vblank_r      <= 1'b0;
      vsync_r       <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      div_cnt_r     <= div_nxt_s;
      ce_pix_r      <= ce_nxt_s;
      hcount_r      <= hcount_nxt_s;
      vcount_r      <= vcount_nxt_s;
      line_rep_r    <= line_rep_nxt_s;
      pal_l_r       <= pal_nxt_s;
      sd_l_r        <= sd_nxt_s;
      init_r        <= 1'b1;
      hblank_r      <= hblank_nxt_s;
      hsync_r       <= hsync_nxt_s;
      vblank_r      <= vblank_nxt_s;
      vsync_r       <= vsync_nxt_s;
      frame_start_r <= frame_wrap_s;
    end
  end

  assign vid.ce_pix      = ce_pix_r;
  assign vid.hblank      = hblank_r;
  assign vid.hsync       = hsync_r;
  assign vid.vblank      = vblank_r;
  assign vid.vsync       = vsync_r;
  assign vid.hcount      = hcount_r;
  assign vid.vcount      = vcount_r;
  assign vid.line_rep    = line_rep_r;
  assign vid.frame_start = frame_start_r;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen with a shrunken raster (16 px x 10/12 lines,
// 8 clocks per pixel) so whole frames fit in a short run; edges counted from reset release.
module tb_video_timing_gen;
  logic sys_clk;
  logic reset_n;
  logic pal;
  logic scandouble;
  int   edges;
  int   n_checks;
  int   n_pass;

  video_timing_gen_if vif ();

  video_timing_gen #(
    .CE_DIV(8), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_TOTAL(16),
    .V_ACTIVE(6), .V_FP_NTSC(1), .V_FP_PAL(2), .V_SYNC(2),
    .V_TOTAL_NTSC(10), .V_TOTAL_PAL(12)
  ) dut (
    .sys_clk(sys_clk),
    .reset_n(reset_n),
    .pal(pal),
    .scandouble(scandouble),
    .vid(vif)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s at edge %0d: got %0d expected %0d", tag, edges, obs, exp);
  endtask

  // advance to the given edge count, then settle 1 ns past the edge
  task automatic goto(input int e);
    while (edges < e) begin
      @(posedge sys_clk);
      edges++;
    end
    #1;
  endtask

  function automatic int all_out();
    return int'({vif.ce_pix, vif.hblank, vif.hsync, vif.vblank, vif.vsync,
                 vif.line_rep, vif.frame_start, vif.hcount, vif.vcount});
  endfunction

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    edges      = 0;
    reset_n    = 1'b0;
    pal        = 1'b0;
    scandouble = 1'b0;
    repeat (5) @(posedge sys_clk);
    #1;
    chk("reset_outputs", all_out(), 0);
    @(negedge sys_clk);
    reset_n = 1'b1;
    edges   = 0;

    // divider and first pixels
    goto(1);    chk("post_release_zero", all_out(), 0);
    goto(7);    chk("ce_before_8", vif.ce_pix, 0);
    goto(8);    chk("ce_first", vif.ce_pix, 1);
                chk("hcount_first_ce", vif.hcount, 0);
    goto(9);    chk("ce_one_wide", vif.ce_pix, 0);
                chk("hcount_1", vif.hcount, 1);
    goto(16);   chk("ce_period_8", vif.ce_pix, 1);
                chk("hcount_second_ce", vif.hcount, 1);
    goto(17);   chk("hcount_2", vif.hcount, 2);

    // horizontal timing
    goto(64);   chk("hblank_low_h7", vif.hblank, 0);
    goto(65);   chk("hcount_8", vif.hcount, 8);
                chk("hblank_rise", vif.hblank, 1);
    goto(80);   chk("hsync_low_h9", vif.hsync, 0);
    goto(81);   chk("hsync_rise_h10", vif.hsync, 1);
    goto(97);   chk("hsync_high_h12", vif.hsync, 1);
    goto(105);  chk("hsync_fall_h13", vif.hsync, 0);
    goto(121);  chk("hcount_last", vif.hcount, 15);
    goto(129);  chk("hwrap_hcount", vif.hcount, 0);
                chk("hwrap_vcount", vif.vcount, 1);
                chk("hblank_clear", vif.hblank, 0);

    // NTSC vertical timing
    goto(768);  chk("vblank_low_v5", vif.vblank, 0);
    goto(769);  chk("vcount_6", vif.vcount, 6);
                chk("vblank_rise", vif.vblank, 1);
    goto(896);  chk("vsync_low_v6", vif.vsync, 0);
    goto(897);  chk("vsync_rise_v7", vif.vsync, 1);
    goto(1152); chk("vsync_high_v8", vif.vsync, 1);
    goto(1153); chk("vsync_fall_v9", vif.vsync, 0);
    goto(1280); chk("fs_low_before_wrap", vif.frame_start, 0);
                chk("vcount_last_ntsc", vif.vcount, 9);
    goto(1281); chk("fs_ntsc_wrap", vif.frame_start, 1);
                chk("wrap_origin", int'({vif.hcount, vif.vcount}), 0);
                chk("vblank_clear", vif.vblank, 0);
    goto(1282); chk("fs_one_wide", vif.frame_start, 0);

    // PAL requested mid-frame: takes effect one frame later
    goto(1665); chk("vcount_3", vif.vcount, 3);
    pal = 1'b1;
    goto(2560); chk("ntsc_kept_v9", vif.vcount, 9);
    goto(2561); chk("fs_still_ntsc", vif.frame_start, 1);
                chk("vcount_wrap_ntsc", vif.vcount, 0);
    goto(3457); chk("pal_no_vsync_v7", vif.vsync, 0);
    goto(3585); chk("vcount_8_pal", vif.vcount, 8);
                chk("pal_vsync_v8", vif.vsync, 1);
    goto(3841); chk("pal_vcount_10", vif.vcount, 10);
                chk("pal_no_fs_v10", vif.frame_start, 0);
    goto(3969); chk("pal_vsync_off_v11", vif.vsync, 0);
                chk("pal_vcount_11", vif.vcount, 11);
    goto(4097); chk("fs_pal_period", vif.frame_start, 1);
                chk("vcount_wrap_pal", vif.vcount, 0);

    // scandouble (and back to NTSC) requested mid-frame
    goto(4200);
    scandouble = 1'b1;
    pal        = 1'b0;
    goto(5632); chk("sd_pending_no_fs", vif.frame_start, 0);
    goto(5633); chk("fs_sd_switch", vif.frame_start, 1);
                chk("line_rep_clear", vif.line_rep, 0);
    goto(5636); chk("sd_ce_restart_low", vif.ce_pix, 0);
    goto(5637); chk("sd_ce_first", vif.ce_pix, 1);
    goto(5638); chk("sd_hcount_1", vif.hcount, 1);
    goto(5641); chk("sd_ce_period_4", vif.ce_pix, 1);
    goto(5697); chk("sd_hcount_last", vif.hcount, 15);
                chk("sd_first_pass", vif.line_rep, 0);
    goto(5698); chk("sd_line_rep_set", vif.line_rep, 1);
                chk("sd_vcount_held", vif.vcount, 0);
    goto(5762); chk("sd_line_rep_clr", vif.line_rep, 0);
                chk("sd_vcount_1", vif.vcount, 1);
    goto(6529); chk("sd_vsync_low_v6", vif.vsync, 0);
    goto(6530); chk("sd_vcount_7", vif.vcount, 7);
                chk("sd_vsync_rise", vif.vsync, 1);
    goto(6785); chk("sd_vsync_4th_line", vif.vsync, 1);
                chk("sd_rep_v8", vif.line_rep, 1);
    goto(6786); chk("sd_vsync_fall", vif.vsync, 0);
    goto(6914); chk("sd_fs_wrap", vif.frame_start, 1);
                chk("sd_wrap_origin", int'({vif.hcount, vif.vcount, vif.line_rep}), 0);
    goto(8193); chk("sd_no_early_fs", vif.frame_start, 0);
    goto(8194); chk("sd_frame_period", vif.frame_start, 1);

    // asynchronous reset between edges mid-line
    goto(8470); chk("pre_rst_hcount", vif.hcount, 5);
                chk("pre_rst_vcount", vif.vcount, 2);
    #2;
    scandouble = 1'b0;
    reset_n    = 1'b0;
    #1;
    chk("async_rst_zero", all_out(), 0);
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_held_zero", all_out(), 0);
    @(negedge sys_clk);
    reset_n = 1'b1;
    edges   = 0;
    goto(1);  chk("re_release_zero", all_out(), 0);
    goto(7);  chk("re_ce_before_8", vif.ce_pix, 0);
    goto(8);  chk("re_ce_first", vif.ce_pix, 1);
    goto(9);  chk("re_hcount_1", vif.hcount, 1);
              chk("re_vcount_0", vif.vcount, 0);
    goto(16); chk("re_ce_period_8", vif.ce_pix, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Raster timing generator that sits directly upstream of mycore's video output. It produces the pixel clock-enable, blanking and sync strobes, and pixel/line counters for the Test_V810 video path. Supports NTSC/PAL line counts and a scandoubled (2x line rate) mode; the pattern/framebuffer stage consumes hcount/vcount and drives video in step with ce_pix.

Parameters:
CE_DIV, 8, sys_clk cycles per pixel in normal mode (even, >=4); scandouble uses CE_DIV/2
H_ACTIVE, 256, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 32, hsync width (pixels)
H_TOTAL, 340, pixels per line
V_ACTIVE, 240, visible lines per frame
V_FP_NTSC, 3, vertical front porch, NTSC (lines)
V_FP_PAL, 27, vertical front porch, PAL (lines)
V_SYNC, 3, vsync width (lines)
V_TOTAL_NTSC, 262, lines per NTSC frame
V_TOTAL_PAL, 312, lines per PAL frame

Ports:
sys_clk  in  1  system clock
reset_n  in  1  asynchronous reset, active-low
pal  in  1  1 = PAL line count, 0 = NTSC
scandouble  in  1  1 = double line rate, each source line output twice
ce_pix  out  1  pixel clock-enable, one sys_clk wide
hblank  out  1  high when hcount >= H_ACTIVE
hsync  out  1  active-high horizontal sync
vblank  out  1  high when vcount >= V_ACTIVE
vsync  out  1  active-high vertical sync
hcount  out  10  current pixel 0..H_TOTAL-1
vcount  out  10  current source line 0..V_TOTAL-1
line_rep  out  1  scandouble: 0 = first, 1 = repeated output line; 0 otherwise
frame_start  out  1  one sys_clk pulse at wrap to (0,0)

Behaviour:
- Clock/reset: single sys_clk domain; reset_n is asynchronous, active-low; all flops clear asynchronously on reset_n low, release synchronous to sys_clk.
- Reset values: every output 0; divider 0; pal_l/sd_l latched from inputs on the first sys_clk edge after release.
- Divider: div_cnt counts 0..D-1, D = CE_DIV (sd_l=0) or CE_DIV/2 (sd_l=1); ce_pix registered high in the cycle after div_cnt == D-1. First ce_pix on the D-th rising edge after reset release (cycle 8 at default).
- Counters advance only on edges where ce_pix is high. hcount wraps H_TOTAL-1 -> 0.
- On hcount wrap: if sd_l=0, vcount increments; if sd_l=1, line_rep toggles and vcount increments only when line_rep was 1.
- vcount wraps V_TOTAL-1 -> 0, where V_TOTAL = V_TOTAL_PAL if pal_l else V_TOTAL_NTSC.
- Decode is registered from next-state counter values, so hblank/hsync/vblank/vsync always change in the same cycle as hcount/vcount (0-cycle skew vs counters):
  - hsync = H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
  - vsync = V_ACTIVE+VFP <= vcount < V_ACTIVE+VFP+V_SYNC, with VFP chosen by pal_l.
  - In scandouble, vsync spans 2*V_SYNC output lines.
- frame_start: high for exactly one sys_clk, in the same cycle that counters become (0,0) with line_rep 0. Not asserted out of reset.
- Mode latching: pal and scandouble are sampled into pal_l/sd_l only at frame wrap (same edge as frame_start). Mid-frame changes have no effect until the next frame.
  - On a scandouble change, div_cnt restarts at 0 and line_rep clears.
- Frame period is identical in both scandouble settings: V_TOTAL*H_TOTAL*CE_DIV sys_clk cycles.
- Bounds: hcount/vcount never exceed TOTAL-1. H_TOTAL and V_TOTAL_PAL must be <= 1023; out-of-range parameters are unsupported.
- Reset mid-line: all outputs drop to 0 immediately, no glitch after release; timing restarts as from power-up.

Test Plan:
- Reset: hold reset_n=0 for 5 cycles, then release -> all outputs 0; first ce_pix on cycle 8; ce_pix period 8; hcount=1 after second ce.
- Line timing, NTSC defaults: hblank rises at hcount 256 (sys_clk 2048 after first ce); hsync high for hcount 272..303 (256 clocks); line period 2720 clocks.
- NTSC frame: vblank rises at vcount 240; vsync high for lines 243..245; frame_start period 262*2720 = 712640 clocks.
- PAL switch: raise pal at vcount 100 -> current frame still wraps at 262; next frame has vsync on lines 267..269 and wraps at 312 (period 848640 clocks).
- Scandouble: raise scandouble mid-frame -> applies at next frame_start; ce_pix period 4; line_rep toggles each 1360 clocks; vcount steps every 2720 clocks; frame period stays 712640.
- Async reset mid-operation: drop reset_n at hcount 150, vcount 20, between clock edges -> outputs zero before the next edge; after release, behaviour matches the Reset scenario.
